// File: rtl/tmds_pkg.sv
// TMDS shared definitions.
// Purpose: symbol width, the four control-token codes, and the receive
//          alignment FSM state encoding.
// Users:   the receive decoder (tmds_decoder, tmds_symbol_decode) and the
//          transmit encoder, which takes its token codes from here.
// Ports:   none (package).
package tmds_pkg;

  localparam int SYM_W = 10;

  // Control tokens as q[9:0]. The name suffix is the {C1,C0} value carried.
  localparam logic [SYM_W-1:0] TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOKEN_11 = 10'b1010101011;

  localparam logic [3:0] OFFSET_MAX = 4'd9;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // True when q is one of the four control tokens.
  function automatic logic is_token(input logic [SYM_W-1:0] q);
    logic hit;
    case (q)
      TOKEN_00, TOKEN_01, TOKEN_10, TOKEN_11: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Next bit offset, wrapping from 9 back to 0.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    logic [3:0] nxt;
    if (off >= OFFSET_MAX) begin
      nxt = 4'd0;
    end else begin
      nxt = off + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// TMDS symbol decoder (combinational).
// Purpose: turns one aligned 10-bit TMDS symbol into either a control value
//          or an 8-bit data byte.
// Ports:   q       in  10  aligned symbol, q[0] earliest bit
//          data    out 8   decoded byte (0 for control tokens)
//          ctrl    out 2   {C1,C0} for control tokens (0 for data)
//          is_ctrl out 1   1 when q is a control token
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] q,
  output logic [7:0]       data,
  output logic [1:0]       ctrl,
  output logic             is_ctrl
);

  logic [7:0] d_s;
  logic [6:0] x_s;

  // Undo the optional inversion, then the XOR/XNOR chain between neighbours.
  assign d_s = q[9] ? ~q[7:0] : q[7:0];
  assign x_s = d_s[7:1] ^ d_s[6:0];

  // Token lookup; anything that is not a token decodes as data.
  always_comb begin
    data    = 8'h00;
    ctrl    = 2'b00;
    is_ctrl = 1'b1;
    case (q)
      TOKEN_00: ctrl = 2'b00;
      TOKEN_01: ctrl = 2'b01;
      TOKEN_10: ctrl = 2'b10;
      TOKEN_11: ctrl = 2'b11;
      default: begin
        is_ctrl = 1'b0;
        data    = {(q[8] ? x_s : ~x_s), d_s[0]};
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with automatic word alignment.
// Purpose: selects a 10-bit symbol from the last two deserializer words at
//          the current bit offset, decodes it, and hunts for the offset at
//          which runs of control tokens appear during blanking.
// Ports:   clock     in  1   pixel clock
//          reset_n   in  1   asynchronous active-low reset
//          raw_in    in  10  deserializer word, bit 0 earliest
//          data_out  out 8   decoded byte, valid when de_out=1
//          ctrl_out  out 2   {C1,C0}, valid when de_out=0 and aligned=1
//          de_out    out 1   1 = data symbol
//          aligned   out 1   1 while locked
//          offset    out 4   current bit offset 0..9
// Latency: symbol selected in cycle t shows on the outputs in cycle t+2.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_DWELL = 1024,
  parameter int TIMEOUT      = 2048
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [SYM_W-1:0] raw_in,
  output logic [7:0]       data_out,
  output logic [1:0]       ctrl_out,
  output logic             de_out,
  output logic             aligned,
  output logic [3:0]       offset
);

  localparam int RUN_W   = (LOCK_COUNT   > 2) ? $clog2(LOCK_COUNT)   : 1;
  localparam int DWELL_W = (SEARCH_DWELL > 2) ? $clog2(SEARCH_DWELL) : 1;
  localparam int WD_W    = (TIMEOUT      > 2) ? $clog2(TIMEOUT)      : 1;

  // "Last" values: reaching LOCK_COUNT means seeing a token while already at
  // LOCK_COUNT-1, so the counters never need to hold the parameter itself.
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);

  logic [SYM_W-1:0]   prev_raw_r;
  logic [2*SYM_W-1:0] window_s;
  logic [SYM_W-1:0]   symbol_s;
  logic [SYM_W-1:0]   sym_r;
  logic               tok_r;

  logic [7:0] dec_data_s;
  logic [1:0] dec_ctrl_s;
  logic       dec_is_ctrl_s;

  state_e             state_r, state_next_s;
  logic [3:0]         offset_r, offset_next_s;
  logic [RUN_W-1:0]   run_r, run_next_s;
  logic [DWELL_W-1:0] dwell_r, dwell_next_s;
  logic [WD_W-1:0]    wd_r, wd_next_s;

  // Older word sits in the low half, so bit 0 of the window is the earliest.
  assign window_s = {raw_in, prev_raw_r};
  assign symbol_s = window_s[offset_r +: SYM_W];
  assign offset   = offset_r;

  // Previous deserializer word, forming the low half of the window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_raw_r <= 10'd0;
    end else begin
      prev_raw_r <= raw_in;
    end
  end

  // Stage 1: selected symbol and its token classification.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sym_r <= 10'd0;
      tok_r <= 1'b0;
    end else begin
      sym_r <= symbol_s;
      tok_r <= is_token(symbol_s);
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .q       (sym_r),
    .data    (dec_data_s),
    .ctrl    (dec_ctrl_s),
    .is_ctrl (dec_is_ctrl_s)
  );

  // Alignment FSM next-state and counter logic.
  always_comb begin
    state_next_s  = state_r;
    offset_next_s = offset_r;
    run_next_s    = run_r;
    dwell_next_s  = dwell_r;
    wd_next_s     = wd_r;
    case (state_r)
      ST_SEARCH: begin
        wd_next_s = '0;
        // Lock is tested first so a run finishing on the last dwell cycle
        // keeps the offset that produced it.
        if (tok_r && (run_r == RUN_LAST)) begin
          state_next_s = ST_LOCKED;
          run_next_s   = '0;
          dwell_next_s = '0;
        end else if (dwell_r == DWELL_LAST) begin
          offset_next_s = next_offset(offset_r);
          run_next_s    = '0;
          dwell_next_s  = '0;
        end else begin
          if (!tok_r) begin
            run_next_s = '0;
          end else if (run_r < RUN_LAST) begin
            run_next_s = run_r + RUN_W'(1);
          end else begin
            run_next_s = run_r;
          end
          dwell_next_s = dwell_r + DWELL_W'(1);
        end
      end
      ST_LOCKED: begin
        run_next_s   = '0;
        dwell_next_s = '0;
        if (tok_r) begin
          wd_next_s = '0;
        end else if (wd_r == WD_LAST) begin
          state_next_s  = ST_SEARCH;
          offset_next_s = next_offset(offset_r);
          wd_next_s     = '0;
        end else begin
          wd_next_s = wd_r + WD_W'(1);
        end
      end
      default: begin
        state_next_s  = ST_SEARCH;
        offset_next_s = 4'd0;
        run_next_s    = '0;
        dwell_next_s  = '0;
        wd_next_s     = '0;
      end
    endcase
  end

  // Alignment FSM state, offset and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_SEARCH;
      offset_r <= 4'd0;
      run_r    <= '0;
      dwell_r  <= '0;
      wd_r     <= '0;
    end else begin
      state_r  <= state_next_s;
      offset_r <= offset_next_s;
      run_r    <= run_next_s;
      dwell_r  <= dwell_next_s;
      wd_r     <= wd_next_s;
    end
  end

  // Stage 2: decoded outputs, gated by the state being entered so that
  // lock and loss of lock line up exactly with the aligned flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= 8'h00;
      ctrl_out <= 2'b00;
      de_out   <= 1'b0;
      aligned  <= 1'b0;
    end else if (state_next_s == ST_LOCKED) begin
      data_out <= dec_data_s;
      ctrl_out <= dec_ctrl_s;
      de_out   <= ~dec_is_ctrl_s;
      aligned  <= 1'b1;
    end else begin
      data_out <= 8'h00;
      ctrl_out <= 2'b00;
      de_out   <= 1'b0;
      aligned  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: alignment, decode table, dwell/lock race,
// watchdog timeout, offset wrap, rotated-stream search and async reset.
module tb_tmds_decoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] raw_in = 10'd0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       aligned;
  logic [3:0] offset;

  int checks = 0;
  int failures = 0;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DFF = 10'h200;  // decodes to 8'hFF

  tmds_decoder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .raw_in   (raw_in),
    .data_out (data_out),
    .ctrl_out (ctrl_out),
    .de_out   (de_out),
    .aligned  (aligned),
    .offset   (offset)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one word, let the clock take it, sample 1 time unit later.
  task automatic tick(input logic [9:0] w);
    raw_in = w;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    raw_in  = 10'd0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Offset-0 decode table: symbol and expected {de, ctrl, data}.
  logic [9:0]  sym_tbl [10];
  logic [10:0] exp_tbl [10];

  initial begin
    logic [9:0] prev_sym;
    logic [9:0] cur_sym;
    logic       lock_seen;
    logic       data_seen;
    int         pos;

    sym_tbl = '{DFF, 10'h100, 10'h101, 10'h00F, 10'h33C, T10, T11, T01, T00, DFF};
    exp_tbl = '{{1'b1, 2'b00, 8'hFF}, {1'b1, 2'b00, 8'h00}, {1'b1, 2'b00, 8'h03},
                {1'b1, 2'b00, 8'hEF}, {1'b1, 2'b00, 8'h45}, {1'b0, 2'b10, 8'h00},
                {1'b0, 2'b11, 8'h00}, {1'b0, 2'b01, 8'h00}, {1'b0, 2'b00, 8'h00},
                {1'b1, 2'b00, 8'hFF}};

    // ---- Reset state ----
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {5'd0, de_out, ctrl_out, data_out}, 16'd0);
    check("reset_aligned", {15'd0, aligned}, 16'd0);
    check("reset_offset", {12'd0, offset}, 16'd0);

    // ---- Aligned stream at offset 0, then decode table ----
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      tick(T00);
      if (n == 9) check("lock_early", {15'd0, aligned}, 16'd0);
      if (n == 10) begin
        check("lock_after_8", {15'd0, aligned}, 16'd1);
        check("lock_ctrl00", {5'd0, de_out, ctrl_out, data_out}, 16'd0);
      end
    end
    for (int j = 0; j < 12; j++) begin
      tick((j < 10) ? sym_tbl[j] : DFF);
      if (j >= 2) check($sformatf("decode_%0d", j - 2), {5'd0, de_out, ctrl_out, data_out},
                        {5'd0, exp_tbl[j - 2]});
    end
    check("decode_offset", {12'd0, offset}, 16'd0);

    // ---- Lock vs dwell race, watchdog timeout, offset wrap ----
    do_reset();
    for (int n = 1; n <= 12290; n++) begin
      tick((n >= 1015 && n <= 1022) ? T00 : DFF);
      if (n == 1000) check("search_suppress", {4'd0, aligned, de_out, ctrl_out, data_out}, 16'd0);
      if (n == 1023) check("race_pre", {11'd0, aligned, offset}, 16'h0000);
      if (n == 1024) check("race_lock", {11'd0, aligned, offset}, 16'h0010);
      if (n == 1030) check("locked_data", {5'd0, de_out, ctrl_out, data_out}, 16'h04FF);
      if (n == 3071) check("wd_pre", {15'd0, aligned}, 16'd1);
      if (n == 3072) begin
        check("wd_drop", {11'd0, aligned, offset}, 16'h0001);
        check("wd_outputs", {5'd0, de_out, ctrl_out, data_out}, 16'd0);
      end
      if (n == 4096) check("step_after_wd", {12'd0, offset}, 16'd2);
      if (n == 12287) check("offset_9", {12'd0, offset}, 16'd9);
      if (n == 12288) check("offset_wrap", {12'd0, offset}, 16'd0);
    end

    // ---- Stream rotated by 3 bits, 640 data / 160 tokens (C1C0=01) ----
    do_reset();
    prev_sym  = 10'd0;
    lock_seen = 1'b0;
    data_seen = 1'b0;
    for (int n = 1; n <= 4200; n++) begin
      pos     = (n - 1) % 800;
      cur_sym = (pos < 640) ? DFF : T01;
      tick({cur_sym[6:0], prev_sym[9:7]});
      prev_sym = cur_sym;
      if (n == 1023) check("rot_off0", {11'd0, aligned, offset}, 16'h0000);
      if (n == 1024) check("rot_off1", {11'd0, aligned, offset}, 16'h0001);
      if (n == 2048) check("rot_off2", {11'd0, aligned, offset}, 16'h0002);
      if (n == 3072) check("rot_off3", {11'd0, aligned, offset}, 16'h0003);
      if (!lock_seen && aligned) begin
        lock_seen = 1'b1;
        check("rot_lock_offset", {12'd0, offset}, 16'd3);
        check("rot_lock_ctrl01", {5'd0, de_out, ctrl_out, data_out}, 16'h0100);
      end else if (lock_seen && !data_seen && de_out) begin
        data_seen = 1'b1;
        check("rot_data", {8'd0, data_out}, 16'h00FF);
      end
    end
    check("rot_lock_seen", {15'd0, lock_seen}, 16'd1);
    check("rot_data_seen", {15'd0, data_seen}, 16'd1);
    check("rot_still_locked", {11'd0, aligned, offset}, 16'h0013);

    // ---- Asynchronous reset while locked, then relock ----
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", {4'd0, aligned, de_out, ctrl_out, data_out}, 16'd0);
    check("async_rst_off", {12'd0, offset}, 16'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick((n <= 7 || (n >= 11 && n <= 18)) ? T00 : DFF);
      if (n == 10) check("relock_7_tokens", {15'd0, aligned}, 16'd0);
      if (n == 19) check("relock_pre", {15'd0, aligned}, 16'd0);
      if (n == 20) check("relock_8_tokens", {11'd0, aligned, offset}, 16'h0010);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
